// File: rtl/mfi_pc_bwd_multi_check.sv
// Backward-PC consistency checker for the MFI retirement interface.
// Captures the target instruction (order inst_order, pc_wdata) and its successor
// (order inst_order+1, pc_rdata), in either order, and checks that they agree.
// Ports:
//   clock, reset   - rising-edge clock, asynchronous active-low reset
//   check          - qualifies target capture
//   inst_order     - order of the target instruction (static after reset)
//   mfi_valid      - per-channel retire valid, channel 0 oldest
//   mfi_order      - per-channel order, channel i at [i*ORDER_W +: ORDER_W]
//   mfi_pc_rdata   - per-channel PC of the retiring instruction
//   mfi_pc_wdata   - per-channel next PC
//   done/pass/fail - registered sticky verdict
//   fail_cause     - 0 none, 1 mismatch, 2 misaligned, 3 duplicate, 4 timeout
module mfi_pc_bwd_multi_check #(
  parameter int unsigned NRET    = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ORDER_W = 32,
  parameter int unsigned IALIGN  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    check,
  input  logic [ORDER_W-1:0]      inst_order,
  input  logic [NRET-1:0]         mfi_valid,
  input  logic [NRET*ORDER_W-1:0] mfi_order,
  input  logic [NRET*XLEN-1:0]    mfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]    mfi_pc_wdata,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic [2:0]              fail_cause
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] CauseNone     = 3'd0;
  localparam logic [2:0] CauseMismatch = 3'd1;
  localparam logic [2:0] CauseMisalign = 3'd2;
  localparam logic [2:0] CauseDup      = 3'd3;
  localparam logic [2:0] CauseTimeout  = 3'd4;

  typedef enum logic [2:0] {
    StWait, StHaveTgt, StHaveSuc, StCompare, StPass, StFail
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   exp_pc_q, exp_pc_d;
  logic [XLEN-1:0]   act_pc_q, act_pc_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        cause_q, cause_d;
  logic              done_q, pass_q, fail_q;

  logic [ORDER_W-1:0] suc_order;
  logic [NRET-1:0]    tgt_hit, suc_hit;
  logic [XLEN-1:0]    tgt_pc, suc_pc;
  logic               any_tgt, any_suc, tgt_multi, suc_multi;
  logic               misaligned;

  // Wraps to 0 when inst_order is all ones.
  assign suc_order = inst_order + ORDER_W'(1);

  always_comb begin
    tgt_hit = '0;
    suc_hit = '0;
    tgt_pc  = '0;
    suc_pc  = '0;
    for (int i = 0; i < int'(NRET); i++) begin
      tgt_hit[i] = mfi_valid[i] & check &
                   (mfi_order[i*ORDER_W +: ORDER_W] == inst_order);
      suc_hit[i] = mfi_valid[i] & (mfi_order[i*ORDER_W +: ORDER_W] == suc_order);
    end
    // Scan high to low so the lowest-index hit is the one that sticks.
    for (int i = int'(NRET) - 1; i >= 0; i--) begin
      if (tgt_hit[i]) tgt_pc = mfi_pc_wdata[i*XLEN +: XLEN];
      if (suc_hit[i]) suc_pc = mfi_pc_rdata[i*XLEN +: XLEN];
    end
  end

  assign any_tgt   = |tgt_hit;
  assign any_suc   = |suc_hit;
  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign tgt_multi = |(tgt_hit & (tgt_hit - NRET'(1)));
  assign suc_multi = |(suc_hit & (suc_hit - NRET'(1)));

  assign misaligned = (IALIGN == 32) ? exp_pc_q[1] : 1'b0;

  always_comb begin
    state_d  = state_q;
    exp_pc_d = exp_pc_q;
    act_pc_d = act_pc_q;
    timer_d  = timer_q;
    cause_d  = cause_q;
    unique case (state_q)
      StWait: begin
        timer_d = '0;
        if (tgt_multi || suc_multi) begin
          state_d = StFail;
          cause_d = CauseDup;
        end else begin
          if (any_tgt) act_pc_d = tgt_pc;
          if (any_suc) exp_pc_d = suc_pc;
          if (any_tgt && any_suc) state_d = StCompare;
          else if (any_tgt)       state_d = StHaveTgt;
          else if (any_suc)       state_d = StHaveSuc;
        end
      end
      StHaveTgt: begin
        if (any_tgt || suc_multi) begin
          state_d = StFail;
          cause_d = CauseDup;
        end else if (any_suc) begin
          exp_pc_d = suc_pc;
          state_d  = StCompare;
        end else if ((TIMEOUT > 0) && (timer_q == TW'(TIMEOUT - 1))) begin
          state_d = StFail;
          cause_d = CauseTimeout;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StHaveSuc: begin
        if (any_suc || tgt_multi) begin
          state_d = StFail;
          cause_d = CauseDup;
        end else if (any_tgt) begin
          act_pc_d = tgt_pc;
          state_d  = StCompare;
        end
      end
      StCompare: begin
        // Both items are already held, so any further hit is a duplicate.
        if (any_tgt || any_suc) begin
          state_d = StFail;
          cause_d = CauseDup;
        end else if (exp_pc_q != act_pc_q) begin
          state_d = StFail;
          cause_d = CauseMismatch;
        end else if (misaligned) begin
          state_d = StFail;
          cause_d = CauseMisalign;
        end else begin
          state_d = StPass;
        end
      end
      StPass, StFail: ;
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StWait;
      exp_pc_q <= '0;
      act_pc_q <= '0;
      timer_q  <= '0;
      cause_q  <= CauseNone;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_pc_q <= exp_pc_d;
      act_pc_q <= act_pc_d;
      timer_q  <= timer_d;
      cause_q  <= cause_d;
      done_q   <= (state_d == StPass) || (state_d == StFail);
      pass_q   <= (state_d == StPass);
      fail_q   <= (state_d == StFail);
    end
  end

  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign fail_cause = cause_q;

endmodule

// File: tb/tb_mfi_pc_bwd_multi_check.sv
// Directed bench for mfi_pc_bwd_multi_check. Four instances share one stimulus:
//   a: IALIGN=32 TIMEOUT=64, b: IALIGN=16, c: TIMEOUT=4, d: TIMEOUT=0.
module tb_mfi_pc_bwd_multi_check;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        check = 1'b0;
  logic [31:0] inst_order = '0;
  logic [1:0]  mfi_valid = '0;
  logic [63:0] mfi_order = '0;
  logic [63:0] mfi_pc_rdata = '0;
  logic [63:0] mfi_pc_wdata = '0;

  logic done_a, pass_a, fail_a, done_b, pass_b, fail_b;
  logic done_c, pass_c, fail_c, done_d, pass_d, fail_d;
  logic [2:0] cause_a, cause_b, cause_c, cause_d;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mfi_pc_bwd_multi_check #(.NRET(2), .IALIGN(32), .TIMEOUT(64)) u_a (
    .clock(clock), .reset(reset), .check(check), .inst_order(inst_order),
    .mfi_valid(mfi_valid), .mfi_order(mfi_order), .mfi_pc_rdata(mfi_pc_rdata),
    .mfi_pc_wdata(mfi_pc_wdata), .done(done_a), .pass(pass_a), .fail(fail_a),
    .fail_cause(cause_a));

  mfi_pc_bwd_multi_check #(.NRET(2), .IALIGN(16), .TIMEOUT(64)) u_b (
    .clock(clock), .reset(reset), .check(check), .inst_order(inst_order),
    .mfi_valid(mfi_valid), .mfi_order(mfi_order), .mfi_pc_rdata(mfi_pc_rdata),
    .mfi_pc_wdata(mfi_pc_wdata), .done(done_b), .pass(pass_b), .fail(fail_b),
    .fail_cause(cause_b));

  mfi_pc_bwd_multi_check #(.NRET(2), .IALIGN(32), .TIMEOUT(4)) u_c (
    .clock(clock), .reset(reset), .check(check), .inst_order(inst_order),
    .mfi_valid(mfi_valid), .mfi_order(mfi_order), .mfi_pc_rdata(mfi_pc_rdata),
    .mfi_pc_wdata(mfi_pc_wdata), .done(done_c), .pass(pass_c), .fail(fail_c),
    .fail_cause(cause_c));

  mfi_pc_bwd_multi_check #(.NRET(2), .IALIGN(32), .TIMEOUT(0)) u_d (
    .clock(clock), .reset(reset), .check(check), .inst_order(inst_order),
    .mfi_valid(mfi_valid), .mfi_order(mfi_order), .mfi_pc_rdata(mfi_pc_rdata),
    .mfi_pc_wdata(mfi_pc_wdata), .done(done_d), .pass(pass_d), .fail(fail_d),
    .fail_cause(cause_d));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    mfi_valid = '0;
    check     = 1'b0;
  endtask

  task automatic retire(input int ch, input logic [31:0] ord, input logic [31:0] rd,
                        input logic [31:0] wd);
    mfi_valid[ch]            = 1'b1;
    mfi_order[ch*32 +: 32]    = ord;
    mfi_pc_rdata[ch*32 +: 32] = rd;
    mfi_pc_wdata[ch*32 +: 32] = wd;
  endtask

  task automatic do_reset(input logic [31:0] ord);
    idle();
    reset      = 1'b0;
    inst_order = ord;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset(32'd5);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_pass", {31'd0, pass_a}, 32'd0);
    chk("rst_fail", {31'd0, fail_a}, 32'd0);
    chk("rst_cause", {29'd0, cause_a}, 32'd0);

    // Target on ch0, successor on ch1 next cycle -> pass two edges later
    check = 1'b1;
    retire(0, 32'd5, 32'h100, 32'h104);
    step();
    mfi_valid = '0;
    retire(1, 32'd6, 32'h104, 32'h108);
    step();
    idle();
    chk("t1_early_done", {31'd0, done_a}, 32'd0);
    step();
    chk("t1_done", {31'd0, done_a}, 32'd1);
    chk("t1_pass", {31'd0, pass_a}, 32'd1);
    chk("t1_fail", {31'd0, fail_a}, 32'd0);
    chk("t1_cause", {29'd0, cause_a}, 32'd0);

    // Successor first (cycle 3), target later (cycle 7) with different PC -> mismatch
    do_reset(32'd5);
    step();
    step();
    retire(1, 32'd6, 32'h200, 32'h204);
    step();
    idle();
    step();
    step();
    step();
    check = 1'b1;
    retire(0, 32'd5, 32'h200, 32'h204);
    step();
    idle();
    step();
    chk("t2_fail", {31'd0, fail_a}, 32'd1);
    chk("t2_pass", {31'd0, pass_a}, 32'd0);
    chk("t2_cause", {29'd0, cause_a}, 32'd1);
    chk("t2_cause_b", {29'd0, cause_b}, 32'd1);

    // Same cycle pair, PC 0x102: misaligned at IALIGN=32, fine at IALIGN=16
    do_reset(32'd5);
    check = 1'b1;
    retire(0, 32'd5, 32'h0fe, 32'h102);
    retire(1, 32'd6, 32'h102, 32'h106);
    step();
    idle();
    step();
    chk("t3_fail_a", {31'd0, fail_a}, 32'd1);
    chk("t3_cause_a", {29'd0, cause_a}, 32'd2);
    chk("t3_pass_b", {31'd0, pass_b}, 32'd1);
    chk("t3_cause_b", {29'd0, cause_b}, 32'd0);

    // Two successor reports in one cycle -> duplicate on the next edge
    do_reset(32'd5);
    retire(0, 32'd6, 32'h300, 32'h304);
    retire(1, 32'd6, 32'h300, 32'h304);
    step();
    idle();
    chk("t4_dup_done", {31'd0, done_a}, 32'd1);
    chk("t4_dup_cause", {29'd0, cause_a}, 32'd3);

    // Target reported again after capture -> duplicate
    do_reset(32'd5);
    check = 1'b1;
    retire(0, 32'd5, 32'h300, 32'h304);
    step();
    mfi_valid = '0;
    retire(1, 32'd5, 32'h300, 32'h304);
    step();
    idle();
    chk("t4_redup_fail", {31'd0, fail_a}, 32'd1);
    chk("t4_redup_cause", {29'd0, cause_a}, 32'd3);

    // Order wrap: target 0xFFFFFFFF, successor order 0
    do_reset(32'hFFFF_FFFF);
    check = 1'b1;
    retire(0, 32'hFFFF_FFFF, 32'h3fc, 32'h400);
    retire(1, 32'd0, 32'h400, 32'h404);
    step();
    idle();
    step();
    chk("t4_wrap_pass", {31'd0, pass_a}, 32'd1);
    chk("t4_wrap_cause", {29'd0, cause_a}, 32'd0);

    // Timeout: c fires exactly 4 edges after capture; d never does
    do_reset(32'd5);
    check = 1'b1;
    retire(0, 32'd5, 32'h500, 32'h504);
    step();
    idle();
    step();
    step();
    step();
    chk("t5_c_not_yet", {31'd0, done_c}, 32'd0);
    step();
    chk("t5_c_done", {31'd0, done_c}, 32'd1);
    chk("t5_c_cause", {29'd0, cause_c}, 32'd4);
    chk("t5_a_waiting", {31'd0, done_a}, 32'd0);
    for (int i = 0; i < 96; i++) step();
    chk("t5_d_done", {31'd0, done_d}, 32'd0);
    chk("t5_d_fail", {31'd0, fail_d}, 32'd0);
    chk("t5_d_pass", {31'd0, pass_d}, 32'd0);

    // Async reset between target and successor discards the target
    do_reset(32'd5);
    check = 1'b1;
    retire(0, 32'd5, 32'h600, 32'h604);
    step();
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk("t6_mid_done", {31'd0, done_a}, 32'd0);
    chk("t6_mid_fail", {31'd0, fail_a}, 32'd0);
    step();
    reset = 1'b1;
    retire(1, 32'd6, 32'h604, 32'h608);
    step();
    idle();
    step();
    step();
    chk("t6_discarded", {31'd0, done_a}, 32'd0);
    check = 1'b1;
    retire(0, 32'd5, 32'h600, 32'h604);
    step();
    idle();
    step();
    chk("t6_new_pass", {31'd0, pass_a}, 32'd1);

    // Async reset with a verdict held clears outputs without a clock edge
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_done", {31'd0, done_a}, 32'd0);
    chk("t6_async_pass", {31'd0, pass_a}, 32'd0);
    step();
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mfi_pc_bwd_multi_check.md
Name: mfi_pc_bwd_multi_check

Overview:
Parametrised backward-PC consistency checker for the MFI retirement interface. It supports NRET retire channels per cycle and configurable widths. It checks that the pc_rdata of the successor instruction (order inst_order+1) equals the pc_wdata of the target instruction (order inst_order), whichever of the two retires first. It also flags misaligned successor PCs, duplicate order reports and successor timeouts, and exposes pass/fail outputs; its formal assertions are built on those outputs.

Parameters:
NRET, 2, retire channels per cycle (1..8); channel 0 is the oldest.
XLEN, 32, PC width.
ORDER_W, 32, mfi_order width; order arithmetic wraps mod 2^ORDER_W.
IALIGN, 32, required successor-PC alignment in bits (16 or 32).
TIMEOUT, 64, max cycles from target capture to successor capture; 0 disables.

Ports:
clock  in  1  sole clock, rising edge.
reset  in  1  asynchronous, active-low reset.
check  in  1  qualifies target capture; held for the check cycle(s).
inst_order  in  ORDER_W  target order; constant after reset.
mfi_valid  in  NRET  per-channel retire valid.
mfi_order  in  NRET*ORDER_W  channel i at [i*ORDER_W +: ORDER_W].
mfi_pc_rdata  in  NRET*XLEN  per-channel PC of retiring instruction.
mfi_pc_wdata  in  NRET*XLEN  per-channel next PC.
done  out  1  verdict reached (sticky until reset).
pass  out  1  done and no error.
fail  out  1  done and error.
fail_cause  out  3  0 none, 1 mismatch, 2 misaligned, 3 duplicate, 4 timeout.

Behaviour:
- Reset (reset=0, async): state=WAIT; done=pass=fail=0; fail_cause=0; captured registers and timer cleared. Reset mid-check discards all captured data.
- Match terms per channel i: tgt_hit[i] = mfi_valid[i] & check & order_i==inst_order; suc_hit[i] = mfi_valid[i] & order_i==inst_order+1 (wrapped, ORDER_W bits).
- Successor capture does not require check.
- Capture registers: exp_pc (successor pc_rdata) and act_pc (target pc_wdata). The lowest-index hit wins.
- Duplicate: 2+ tgt_hit in one cycle, 2+ suc_hit in one cycle, or a hit for an already-captured item. Goes to FAIL cause 3 on the next edge.
- States:
  - WAIT: target only -> HAVE_TGT; successor only -> HAVE_SUC; both the same cycle (any channels) -> COMPARE.
  - HAVE_TGT: timer increments each cycle. Successor hit -> COMPARE. Timer reaching TIMEOUT with no successor (TIMEOUT>0) -> FAIL cause 4.
  - HAVE_SUC: target hit -> COMPARE. No timeout applies.
  - COMPARE (1 cycle): exp_pc!=act_pc -> FAIL cause 1. Else exp_pc misaligned -> FAIL cause 2. Else PASS.
  - Misaligned means bit1 set when IALIGN=32; bit 0 is ignored.
  - PASS/FAIL: terminal until reset. done=1, pass/fail registered. Later hits are ignored, including duplicates.
- Priority when several causes arise the same cycle: duplicate > mismatch > misaligned > timeout.
- Verdict latency: 1 cycle after the second capture edge, i.e. done rises 2 edges after the cycle completing the pair.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- inst_order = 2^ORDER_W-1: successor order is 0 (wrap). This case must be handled.
- Formal wrapper: assert(!fail). When check is high, it assumes some tgt_hit exists.

Test Plan:
- NRET=2, channel 0 target (order 5, wdata 0x104, check=1); next cycle channel 1 order 6, rdata 0x104 -> done=1, pass=1 two edges later.
- Successor first: order 6 rdata 0x200 at cycle 3, target order 5 wdata 0x204 at cycle 7 -> fail=1, fail_cause=1.
- Same cycle, both channels: ch0 order 5 wdata 0x102, ch1 order 6 rdata 0x102, IALIGN=32 -> fail_cause=2. Same stimulus with IALIGN=16 -> pass=1.
- Duplicates: two channels report order 6 in one cycle -> fail_cause=3. Separately, inst_order=0xFFFFFFFF with successor order 0 matching -> pass=1.
- TIMEOUT=4: target captured, no successor -> fail_cause=4 exactly 4 cycles after capture. With TIMEOUT=0 -> done stays 0 for 100 cycles.
- Assert reset low asynchronously between target and successor -> outputs 0 immediately. After release, a new full pair -> pass=1.
